lfsr_arbiter: RTL and testbench

Shares one 26-bit `LFSR` instance (ports `clk`, `rst_n`, `load`, `din[1:26]`, `q[1:26]`) among several requesters, each needing one pseudo-random word. The block seeds the LFSR, holds off requesters during a warm-up period, then issues at most one registered round-robin grant per cycle, returning the LFSR state with each grant. It sits directly beside the `LFSR` instance: it drives `load`/`din` and reads `q`.

---
 rtl/lfsr_arbiter_if.sv | 20 ++
 rtl/lfsr_arbiter.sv | 119 +++++++++++
 tb/tb_lfsr_arbiter.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/lfsr_arbiter_if.sv
// Requester-side bus of lfsr_arbiter: requests, reseed strobe, grants and status.
interface lfsr_arbiter_if #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 26
);
  logic [NREQ-1:0] req;
  logic            seed_wr;
  logic [1:WIDTH]  seed_in;
  logic [NREQ-1:0] gnt;
  logic            rand_vld;
  logic [1:WIDTH]  rand_out;
  logic            busy;
  logic            seed_err;
  logic            lockup;

  modport master (output req, seed_wr, seed_in,
                  input  gnt, rand_vld, rand_out, busy, seed_err, lockup);
  modport slave  (input  req, seed_wr, seed_in,
                  output gnt, rand_vld, rand_out, busy, seed_err, lockup);
endinterface

// File: rtl/lfsr_arbiter.sv
// Seeds a shared LFSR, waits WARMUP cycles, then hands out its state by round-robin grant.
// Optional LFSR all-zero lock-up recovery: define LFSR_ARB_LOCKUP_DET_EN.
module lfsr_arbiter #(
  parameter int             NREQ         = 4,
  parameter int             WIDTH        = 26,
  parameter int             WARMUP       = 8,
  parameter logic [1:WIDTH] DEFAULT_SEED = WIDTH'(26'h2F1112D)
) (
  input  logic                clk,
  input  logic                rst_n,
  lfsr_arbiter_if.slave       bus,
  output logic                lfsr_load,
  output logic [1:WIDTH]      lfsr_din,
  input  logic [1:WIDTH]      lfsr_q
);
  localparam int PW = $clog2(NREQ);

  typedef enum logic [1:0] {S_LOAD, S_WARM, S_SERVE} state_t;

  state_t          r_state, w_next;
  logic [7:0]      r_wcnt;
  logic [1:WIDTH]  r_seed;
  logic [PW-1:0]   r_ptr, w_idx, w_ptr_nxt;
  logic            w_hit, w_lock;
  logic [NREQ-1:0] r_gnt;
  logic            r_vld, r_seed_err;
  logic [1:WIDTH]  r_rand;

`ifdef LFSR_ARB_LOCKUP_DET_EN
  logic r_lockup;
  // An all-zero LFSR never leaves zero; reseed from the default instead.
  assign w_lock     = (r_state != S_LOAD) && (lfsr_q == '0) && !bus.seed_wr;
  assign bus.lockup = r_lockup;
  always_ff @(posedge clk) begin
    if (!rst_n) r_lockup <= 1'b0;
    else        r_lockup <= w_lock;
  end
`else
  assign w_lock     = 1'b0;
  assign bus.lockup = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_LOAD;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (bus.seed_wr || w_lock) w_next = S_LOAD;
    else begin
      case (r_state)
        S_LOAD:  w_next = (WARMUP == 0) ? S_SERVE : S_WARM;
        S_WARM:  w_next = (r_wcnt == 8'(WARMUP - 1)) ? S_SERVE : S_WARM;
        default: w_next = S_SERVE;
      endcase
    end
  end

  always_comb begin
    lfsr_load = (r_state == S_LOAD);
    lfsr_din  = lfsr_load ? r_seed : '0;
    bus.busy  = (r_state != S_SERVE);
  end

  // Rotating priority search: first set request at or above r_ptr, wrapping.
  always_comb begin
    int j;
    j     = 0;
    w_hit = 1'b0;
    w_idx = '0;
    for (int k = 0; k < NREQ; k++) begin
      j = int'(r_ptr) + k;
      if (j >= NREQ) j = j - NREQ;
      if (!w_hit && bus.req[j]) begin
        w_hit = 1'b1;
        w_idx = PW'(j);
      end
    end
    w_ptr_nxt = (w_idx == PW'(NREQ - 1)) ? '0 : w_idx + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) r_wcnt <= '0;
    else if (r_state == S_WARM && w_next == S_WARM) r_wcnt <= r_wcnt + 8'd1;
    else r_wcnt <= '0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_seed     <= DEFAULT_SEED;
      r_ptr      <= '0;
      r_gnt      <= '0;
      r_vld      <= 1'b0;
      r_rand     <= '0;
      r_seed_err <= 1'b0;
    end else begin
      r_gnt      <= '0;
      r_vld      <= 1'b0;
      r_seed_err <= 1'b0;
      if (bus.seed_wr) begin
        r_seed     <= (bus.seed_in == '0) ? DEFAULT_SEED : bus.seed_in;
        r_seed_err <= (bus.seed_in == '0);
      end else if (w_lock) begin
        r_seed <= DEFAULT_SEED;
      end else if (r_state == S_SERVE && w_hit) begin
        r_gnt  <= NREQ'(1) << w_idx;
        r_vld  <= 1'b1;
        r_rand <= lfsr_q;
        r_ptr  <= w_ptr_nxt;
      end
    end
  end

  assign bus.gnt      = r_gnt;
  assign bus.rand_vld = r_vld;
  assign bus.rand_out = r_rand;
  assign bus.seed_err = r_seed_err;
endmodule

// File: tb/tb_lfsr_arbiter.sv
// Self-checking bench for lfsr_arbiter; the bench stands in for the LFSR and drives lfsr_q.
module tb_lfsr_arbiter;
  localparam logic [1:26] DEF = 26'h2F1112D;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic        lfsr_load;
  logic [1:26] lfsr_din;
  logic [1:26] lfsr_q;
  logic [1:26] prev_q;
  logic [1:26] last_rand;

  int checks = 0;
  int failures = 0;

  lfsr_arbiter_if #(.NREQ(4), .WIDTH(26)) bus();

  lfsr_arbiter #(.NREQ(4), .WIDTH(26), .WARMUP(8)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .lfsr_load(lfsr_load), .lfsr_din(lfsr_din), .lfsr_q(lfsr_q)
  );

  always #5 clk = ~clk;

  typedef struct { logic [3:0] req; logic [3:0] gnt; } vec_t;
  typedef struct { logic [3:0] gnt; logic vld; logic [1:26] rnd; } exp_t;
  vec_t vt[14];
  exp_t sb[$];

  function automatic logic [1:26] rnd26();
    logic [31:0] r;
    r = $urandom();
    if (r[25:0] == 26'd0) r = 32'd1;
    return r[25:0];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One clock: prev_q is the lfsr_q the DUT sampled at this edge.
  task automatic tick();
    prev_q = lfsr_q;
    @(posedge clk);
    #1;
    lfsr_q = rnd26();
  endtask

  task automatic wait_serve(input string name);
    int n;
    n = 0;
    while (bus.busy === 1'b1 && n < 40) begin tick(); n++; end
    chk(name, 32'(bus.busy), 32'd0);
  endtask

  initial begin
    int k;
    exp_t e;
    vt[0]  = '{4'b1111, 4'b0001}; vt[1]  = '{4'b1111, 4'b0010};
    vt[2]  = '{4'b1111, 4'b0100}; vt[3]  = '{4'b1111, 4'b1000};
    vt[4]  = '{4'b1111, 4'b0001}; vt[5]  = '{4'b0000, 4'b0000};
    vt[6]  = '{4'b0100, 4'b0100}; vt[7]  = '{4'b0100, 4'b0100};
    vt[8]  = '{4'b1001, 4'b1000}; vt[9]  = '{4'b1001, 4'b0001};
    vt[10] = '{4'b0110, 4'b0010}; vt[11] = '{4'b0011, 4'b0001};
    vt[12] = '{4'b0011, 4'b0010}; vt[13] = '{4'b0000, 4'b0000};

    bus.req = '0; bus.seed_wr = 1'b0; bus.seed_in = '0;
    lfsr_q = rnd26(); prev_q = lfsr_q;
    tick(); tick();
    chk("rst_gnt", 32'(bus.gnt), 32'd0);
    chk("rst_vld", 32'(bus.rand_vld), 32'd0);
    chk("rst_rand", 32'(bus.rand_out), 32'd0);
    chk("rst_seed_err", 32'(bus.seed_err), 32'd0);
    chk("rst_lockup", 32'(bus.lockup), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd1);
    chk("rst_load", 32'(lfsr_load), 32'd1);
    chk("rst_din", 32'(lfsr_din), 32'(DEF));

    // Cycle 1 is LOAD; WARM 2..9; SERVE from 10.
    rst_n = 1'b1;
    for (int c = 2; c <= 11; c++) begin
      tick();
      chk($sformatf("busy_c%0d", c), 32'(bus.busy), (c <= 9) ? 32'd1 : 32'd0);
      chk($sformatf("gnt_c%0d", c), 32'(bus.gnt), 32'd0);
    end
    chk("load_off", 32'(lfsr_load), 32'd0);
    chk("din_off", 32'(lfsr_din), 32'd0);

    last_rand = '0;
    foreach (vt[i]) begin
      bus.req = vt[i].req;
      e.gnt = vt[i].gnt;
      e.vld = (vt[i].gnt != 4'b0000);
      e.rnd = e.vld ? lfsr_q : last_rand;
      last_rand = e.rnd;
      sb.push_back(e);
      tick();
      e = sb.pop_front();
      chk($sformatf("vec%0d_gnt", i), 32'(bus.gnt), 32'(e.gnt));
      chk($sformatf("vec%0d_vld", i), 32'(bus.rand_vld), 32'(e.vld));
      chk($sformatf("vec%0d_rand", i), 32'(bus.rand_out), 32'(e.rnd));
    end

    // Reseed with a concurrent request: seed wins, grant 11 cycles later.
    bus.seed_wr = 1'b1; bus.seed_in = 26'h0000001; bus.req = 4'b0010;
    tick();
    bus.seed_wr = 1'b0;
    chk("reseed_gnt", 32'(bus.gnt), 32'd0);
    chk("reseed_load", 32'(lfsr_load), 32'd1);
    chk("reseed_din", 32'(lfsr_din), 32'h1);
    chk("reseed_err", 32'(bus.seed_err), 32'd0);
    k = 1;
    while (bus.gnt == 4'b0000 && k < 20) begin tick(); k++; end
    chk("reseed_lat", 32'(k), 32'd11);
    chk("reseed_gnt1", 32'(bus.gnt), 32'b0010);
    chk("reseed_rand", 32'(bus.rand_out), 32'(prev_q));

    // Zero seed falls back to the default and flags an error.
    bus.req = '0; bus.seed_wr = 1'b1; bus.seed_in = '0;
    tick();
    bus.seed_wr = 1'b0;
    chk("zseed_err", 32'(bus.seed_err), 32'd1);
    chk("zseed_load", 32'(lfsr_load), 32'd1);
    chk("zseed_din", 32'(lfsr_din), 32'(DEF));
    tick();
    chk("zseed_err_pulse", 32'(bus.seed_err), 32'd0);
    wait_serve("zseed_serve");

    // Reset mid-stream.
    bus.req = 4'b1111;
    tick(); tick();
    chk("stream_vld", 32'(bus.rand_vld), 32'd1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("mrst_gnt", 32'(bus.gnt), 32'd0);
    chk("mrst_vld", 32'(bus.rand_vld), 32'd0);
    chk("mrst_busy", 32'(bus.busy), 32'd1);
    k = 0;
    while (bus.gnt == 4'b0000 && k < 30) begin tick(); k++; end
    chk("mrst_lat", 32'(k), 32'd10);
    chk("mrst_first", 32'(bus.gnt), 32'b0001);

`ifdef LFSR_ARB_LOCKUP_DET_EN
    lfsr_q = '0;
    tick();
    chk("lock_pulse", 32'(bus.lockup), 32'd1);
    chk("lock_gnt", 32'(bus.gnt), 32'd0);
    chk("lock_load", 32'(lfsr_load), 32'd1);
    chk("lock_din", 32'(lfsr_din), 32'(DEF));
    tick();
    chk("lock_pulse_end", 32'(bus.lockup), 32'd0);
`else
    lfsr_q = '0;
    tick();
    chk("nolock_flag", 32'(bus.lockup), 32'd0);
    chk("nolock_vld", 32'(bus.rand_vld), 32'd1);
`endif
    bus.req = '0;
    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule
